// File: rtl/adder_pipe_sat.sv
// Two-stage signed add/sub/accumulate unit with optional saturation and overflow flag.
// Latency 2 cycles from input accept to out_valid; throughput 1 beat/cycle.
// Backpressure: out_ready stalls stage 2, stage 1 fills once, then in_ready drops (no skid buffer).
module adder_pipe_sat #(
    parameter int DATA_W = 32,
    parameter bit SAT_EN = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] adder_out,
    output logic              ovf
);

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [1:0]        s1_mode;
    logic [DATA_W-1:0] acc;

    logic              s2_adv;
    logic              s1_adv;

    logic [DATA_W:0]   a_ext;
    logic [DATA_W:0]   b_ext;
    logic [DATA_W:0]   acc_ext;
    logic [DATA_W:0]   sum;
    logic              sum_ovf;
    logic [DATA_W-1:0] res;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    assign a_ext   = {s1_a[DATA_W-1], s1_a};
    assign b_ext   = {s1_b[DATA_W-1], s1_b};
    assign acc_ext = {acc[DATA_W-1], acc};

    // One extra bit of headroom keeps A - (most negative) exact; overflow is a top-two-bit mismatch.
    always_comb begin
        sum = '0;
        case (s1_mode)
            MODE_ADD: sum = a_ext + b_ext;
            MODE_SUB: sum = a_ext - b_ext;
            MODE_ACC: sum = acc_ext + a_ext;
            default:  sum = '0;
        endcase
        sum_ovf = sum[DATA_W] ^ sum[DATA_W-1];
        if (sum_ovf && SAT_EN)
            res = sum[DATA_W] ? MIN_NEG : MAX_POS;
        else
            res = sum[DATA_W-1:0];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_mode   <= '0;
            out_valid <= 1'b0;
            adder_out <= '0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a    <= in_0;
                    s1_b    <= in_1;
                    s1_mode <= mode;
                end
            end
            // ACC is read and written only here, so chained accumulates see each other's results.
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    adder_out <= res;
                    ovf       <= sum_ovf;
                    if (s1_mode == MODE_ACC)
                        acc <= res;
                    else if (s1_mode == MODE_CLR)
                        acc <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_pipe_sat.sv
// Bench for adder_pipe_sat: saturating and wrapping instances share stimulus; a scoreboard
// queue holds expected results for both, pushed at input accept and popped at output accept.
module tb_adder_pipe_sat;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        in_valid;
    logic [31:0] in_0;
    logic [31:0] in_1;
    logic [1:0]  mode;
    logic        out_ready;

    logic        in_ready_s, out_valid_s, ovf_s;
    logic [31:0] adder_out_s;
    logic        in_ready_w, out_valid_w, ovf_w;
    logic [31:0] adder_out_w;

    typedef struct packed {
        logic [31:0] rs;
        logic        os;
        logic [31:0] rw;
        logic        ow;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] acc_s;
    logic [31:0] acc_w;
    int          checks = 0;
    int          errors = 0;

    always #5 sys_clk = ~sys_clk;

    adder_pipe_sat #(.DATA_W(32), .SAT_EN(1'b1)) u_dut_sat (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_0      (in_0),
        .in_1      (in_1),
        .mode      (mode),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .adder_out (adder_out_s),
        .ovf       (ovf_s)
    );

    adder_pipe_sat #(.DATA_W(32), .SAT_EN(1'b0)) u_dut_wrap (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .in_0      (in_0),
        .in_1      (in_1),
        .mode      (mode),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .adder_out (adder_out_w),
        .ovf       (ovf_w)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers, independent of bit-level tricks.
    function automatic void model(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                                  input bit sat, inout logic [31:0] acc,
                                  output logic [31:0] r, output logic o);
        longint sa, sb, sacc, s;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sacc = longint'($signed(acc));
        case (m)
            2'b00:   s = sa + sb;
            2'b01:   s = sa - sb;
            2'b10:   s = sacc + sa;
            default: s = 0;
        endcase
        o = (s > MAXV) || (s < MINV);
        if (o && sat)
            r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else
            r = s[31:0];
        if (m == 2'b10)
            acc = r;
        else if (m == 2'b11)
            acc = '0;
    endfunction

    // Scoreboard: both handshakes are stable at the falling edge and transfer on the next rising edge.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_rst) begin
            chk("in_ready_match", in_ready_w, in_ready_s);
            if (in_valid && in_ready_s) begin
                model(mode, in_0, in_1, 1'b1, acc_s, e.rs, e.os);
                model(mode, in_0, in_1, 1'b0, acc_w, e.rw, e.ow);
                exp_q.push_back(e);
            end
            if (out_valid_s && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_sat", adder_out_s, e.rs);
                    chk("ovf_sat", ovf_s, e.os);
                    chk("vld_wrap", out_valid_w, 1);
                    chk("res_wrap", adder_out_w, e.rw);
                    chk("ovf_wrap", ovf_w, e.ow);
                end
            end
        end
    end

    // Call #1 after a rising edge; returns #1 after the edge on which the beat was accepted.
    task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_0 = a; in_1 = b; mode = m; in_valid = 1'b1;
        @(negedge sys_clk);
        while (!in_ready_s && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        if (!in_ready_s) chk("send_timeout", 0, 1);
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge sys_clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge sys_clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1; in_valid = 1'b0; in_0 = '0; in_1 = '0; mode = '0; out_ready = 1'b1;
        acc_s = '0; acc_w = '0;
        #23;
        chk("rst_out_valid", out_valid_s, 0);
        chk("rst_in_ready", in_ready_s, 1);
        chk("rst_adder_out", adder_out_s, 0);
        chk("rst_ovf", ovf_s, 0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        // Basic add with latency check
        send(2'b00, -32'sd10, -32'sd10);
        chk("lat_s1", out_valid_s, 0);
        @(posedge sys_clk); #1;
        chk("lat_s2", out_valid_s, 1);
        drain();

        // Overflow on add and on subtracting the most negative value
        send(2'b00, 32'h7FFF_FFFF, 32'h1);
        send(2'b01, 32'h0, 32'h8000_0000);
        send(2'b01, 32'h8000_0000, 32'h1);
        drain();

        // Accumulate 1..10
        send(2'b11, 32'h0, 32'h0);
        for (int i = 1; i <= 10; i++) send(2'b10, i, 32'hDEAD_BEEF);
        drain();

        // Backpressure: two beats fill the pipe, third waits
        out_ready = 1'b0;
        send(2'b00, 32'd1, 32'd1);
        send(2'b00, 32'd2, 32'd2);
        chk("stall_in_ready", in_ready_s, 0);
        in_0 = 32'd3; in_1 = 32'd3; mode = 2'b00; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk); #1;
            chk("stall_hold_rdy", in_ready_s, 0);
            chk("stall_hold_vld", out_valid_s, 1);
            chk("stall_hold_dat", adder_out_s, 2);
        end
        out_ready = 1'b1;
        send(2'b00, 32'd3, 32'd3);
        drain();

        // Accumulator saturation
        send(2'b11, 32'h0, 32'h0);
        send(2'b10, 32'h7FFF_FFF0, 32'h0);
        send(2'b10, 32'h20, 32'h0);
        send(2'b10, 32'hFFFF_FFFF, 32'h0);
        drain();

        // Asynchronous reset with beats in flight and ACC = 55
        send(2'b11, 32'h0, 32'h0);
        for (int i = 1; i <= 10; i++) send(2'b10, i, 32'h0);
        drain();
        out_ready = 1'b0;
        send(2'b00, 32'd7, 32'd7);
        send(2'b00, 32'd8, 32'd8);
        #3;
        sys_rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid_s, 0);
        chk("arst_in_ready", in_ready_s, 1);
        exp_q.delete();
        acc_s = '0;
        acc_w = '0;
        @(posedge sys_clk);
        @(posedge sys_clk); #3;
        sys_rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk); #1;
            chk("post_rst_idle", out_valid_s, 0);
        end
        send(2'b10, 32'd5, 32'd0);
        @(posedge sys_clk); #1;
        chk("post_rst_acc_vld", out_valid_s, 1);
        chk("post_rst_acc_dat", adder_out_s, 5);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
